// File: rtl/iob_cmdrsp_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_cmdrsp_bridge_pkg
// Brief    : Shared types and helpers for the command/response to IOb bridge
// Revision : 1.0 - initial release
// ============================================================================
package iob_cmdrsp_bridge_pkg;

  // Bridge sequencer states: waiting for work, or driving an IOb request
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions
  function automatic int log2c(input int v);
    return $clog2(v);
  endfunction

  // Byte-offset width of one data word
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Beat-count width: must hold the value MAX_BEATS itself
  function automatic int beat_w(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_cmdrsp_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : iob_cmdrsp_bridge_if
// Brief    : CPU command/response bus plus IOb native bus bundle
// Revision : 1.0 - initial release
// ============================================================================
interface iob_cmdrsp_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_mask;
  logic [2:0]            cmd_size;
  // CPU response channel (no backpressure)
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_last;
  logic                  rsp_error;
  // IOb native bus
  logic                  iob_valid;
  logic [ADDR_W-1:0]     iob_addr;
  logic [DATA_W-1:0]     iob_wdata;
  logic [DATA_W/8-1:0]   iob_wstrb;
  logic [DATA_W-1:0]     iob_rdata;
  logic                  iob_ready;

  // Bridge view: slave on the command bus, master on IOb
  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_mask, cmd_size,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_last, rsp_error,
    output iob_valid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_rdata, iob_ready
  );

  // Environment view: drives commands and answers IOb requests
  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_mask, cmd_size,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_last, rsp_error,
    input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
    output iob_rdata, iob_ready
  );

endinterface
`default_nettype wire

// File: rtl/iob_cmdrsp_bridge_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iob_cmd_fifo
// Brief    : DEPTH-entry synchronous command FIFO, head read from storage
// Revision : 1.0 - initial release
// ============================================================================
module iob_cmd_fifo
  import iob_cmdrsp_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic [WIDTH-1:0]       din,
  input  wire logic                   pop,
  output logic      [WIDTH-1:0]       dout,
  output logic                        full,
  output logic                        empty,
  output logic      [log2c(DEPTH):0]  count
);

  localparam int PTR_W = log2c(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_cmdrsp_bridge.sv
`default_nettype none
// ============================================================================
// Module   : iob_cmdrsp_bridge
// Brief    : Split command/response CPU bus to IOb bridge with burst expansion
// Revision : 1.0 - initial release
// ============================================================================
module iob_cmdrsp_bridge
  import iob_cmdrsp_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2,
  parameter int MAX_BEATS = 8,
  parameter int WR_RSP    = 0,
  parameter int RSP_REG   = 0,
  parameter int REMAP     = 0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          boot,
  output logic               busy,
  iob_cmdrsp_bridge_if.slave bus
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = off_w(DATA_W);
  localparam int LOG_MAX = log2c(MAX_BEATS);
  localparam int BEAT_W  = beat_w(MAX_BEATS);
  localparam int CNT_W   = log2c(DEPTH) + 1;

  // One queued command; addr is already the aligned burst base
  typedef struct packed {
    logic              wr;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [BEAT_W-1:0] beats;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BEAT_W-1:0]  r_cnt;
  logic [BEAT_W-1:0]  w_cnt_nxt;
  entry_t             w_push_entry;
  entry_t             w_head;
  logic [ENTRY_W-1:0] w_head_raw;
  logic [ADDR_W-1:0]  w_align;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_issue;
  logic               w_fire;
  logic               w_final;
  logic [ADDR_W-1:0]  w_beat_addr;
  logic [ADDR_W-1:0]  w_out_addr;
  logic               w_rsp_valid;
  logic [DATA_W-1:0]  w_rsp_data;
  logic               w_rsp_last;
  logic               w_rsp_error;

  assign bus.cmd_ready = ~w_full;
  assign w_push        = bus.cmd_valid & ~w_full;
  assign w_head        = w_head_raw;

  // Build the FIFO entry: beat count, clamp flag and aligned base address
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.wr    = bus.cmd_wr;
    w_push_entry.wdata = bus.cmd_wdata;
    w_push_entry.strb  = bus.cmd_wr ? bus.cmd_mask : '0;
    w_align            = {ADDR_W{1'b1}} << bus.cmd_size;
    if (bus.cmd_wr || (int'(bus.cmd_size) <= OFF_W)) begin
      w_push_entry.beats = BEAT_W'(1);
      w_push_entry.addr  = bus.cmd_addr;
    end else begin
      w_push_entry.addr = bus.cmd_addr & w_align;
      if ((int'(bus.cmd_size) - OFF_W) > LOG_MAX) begin
        w_push_entry.beats = BEAT_W'(MAX_BEATS);
        w_push_entry.err   = 1'b1;
      end else begin
        w_push_entry.beats = BEAT_W'(1) << (bus.cmd_size - 3'(OFF_W));
      end
    end
  end

  iob_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_push_entry),
    .pop   (w_pop),
    .dout  (w_head_raw),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_issue = (r_state == ST_ISSUE);
  assign w_fire  = w_issue & bus.iob_ready;
  assign w_final = (r_cnt == (w_head.beats - BEAT_W'(1)));

  // State and beat counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sequencing: a same-cycle push keeps ISSUE so the next request follows directly
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty || w_push) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_fire) begin
          if (w_final) begin
            w_pop     = 1'b1;
            w_cnt_nxt = '0;
            if ((w_count <= CNT_W'(1)) && !w_push) w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + BEAT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_beat_addr = w_head.addr + (ADDR_W'(r_cnt) << OFF_W);

  generate
    if (REMAP != 0) begin : g_remap
      assign w_out_addr = {~boot | w_beat_addr[ADDR_W-1], w_beat_addr[ADDR_W-2:0]};
    end else begin : g_no_remap
      logic w_unused_boot;
      assign w_unused_boot = boot;
      assign w_out_addr    = w_beat_addr;
    end
  endgenerate

  // IOb payload is forced to zero whenever no request is outstanding
  assign bus.iob_valid = w_issue;
  assign bus.iob_addr  = w_issue ? w_out_addr   : '0;
  assign bus.iob_wdata = w_issue ? w_head.wdata : '0;
  assign bus.iob_wstrb = w_issue ? w_head.strb  : '0;
  assign busy          = ~w_empty | w_issue;

  assign w_rsp_valid = w_fire & (~w_head.wr | (WR_RSP != 0));
  assign w_rsp_data  = (w_rsp_valid && !w_head.wr) ? bus.iob_rdata : '0;
  assign w_rsp_last  = w_rsp_valid & (w_head.wr | w_final);
  assign w_rsp_error = w_rsp_valid & w_head.err;

  generate
    if (RSP_REG != 0) begin : g_rsp_reg
      logic              r_rsp_valid;
      logic [DATA_W-1:0] r_rsp_data;
      logic              r_rsp_last;
      logic              r_rsp_error;
      // Response stage delayed by one cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rsp_valid <= 1'b0;
          r_rsp_data  <= '0;
          r_rsp_last  <= 1'b0;
          r_rsp_error <= 1'b0;
        end else begin
          r_rsp_valid <= w_rsp_valid;
          r_rsp_data  <= w_rsp_data;
          r_rsp_last  <= w_rsp_last;
          r_rsp_error <= w_rsp_error;
        end
      end
      assign bus.rsp_valid = r_rsp_valid;
      assign bus.rsp_data  = r_rsp_data;
      assign bus.rsp_last  = r_rsp_last;
      assign bus.rsp_error = r_rsp_error;
    end else begin : g_rsp_comb
      assign bus.rsp_valid = w_rsp_valid;
      assign bus.rsp_data  = w_rsp_data;
      assign bus.rsp_last  = w_rsp_last;
      assign bus.rsp_error = w_rsp_error;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_iob_cmdrsp_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_cmdrsp_bridge
// Brief    : Scoreboard bench for iob_cmdrsp_bridge (WR_RSP=1, RSP_REG=0, REMAP=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_cmdrsp_bridge;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } iob_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_exp_t;

  logic clk;
  logic rst;
  logic boot;
  logic busy;

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  logic hold_ready = 1'b0;
  logic stray_req = 1'b0;

  iob_exp_t exp_iob[$];
  rsp_exp_t exp_rsp[$];

  iob_cmdrsp_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  iob_cmdrsp_bridge #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .DEPTH     (2),
    .MAX_BEATS (8),
    .WR_RSP    (1),
    .RSP_REG   (0),
    .REMAP     (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .boot (boot),
    .busy (busy),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_read(input logic [31:0] addr, input logic last, input logic err);
    iob_exp_t e;
    rsp_exp_t r;
    e.addr = addr; e.strb = 4'h0; e.wdata = 32'h0;
    r.data = mem_model(addr); r.last = last; r.err = err;
    exp_iob.push_back(e);
    exp_rsp.push_back(r);
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
    iob_exp_t e;
    rsp_exp_t r;
    e.addr = addr; e.strb = strb; e.wdata = wdata;
    r.data = 32'h0; r.last = 1'b1; r.err = 1'b0;
    exp_iob.push_back(e);
    exp_rsp.push_back(r);
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input logic [2:0] size);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_mask  = mask;
    bus.cmd_size  = size;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [2:0] size);
    int n;
    n = 0;
    @(posedge clk); #1;
    drive_cmd(wr, addr, wdata, mask, size);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 200);
    if (!bus.cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: got not-ready expected ready addr %0h", addr);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((exp_iob.size() != 0 || exp_rsp.size() != 0 || busy) && n < 500);
    chk({name, "_drain"}, {31'd0, busy, exp_iob.size() + exp_rsp.size()}, 64'd0);
  endtask

  // IOb slave: ready two cycles after a request appears, optional stray pulse when idle
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.iob_ready = 1'b0;
    bus.iob_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.iob_ready = 1'b0;
      bus.iob_rdata = '0;
      if (rst || !bus.iob_valid) begin
        wait_cnt = 0;
        if (stray_req) begin
          bus.iob_ready = 1'b1;
          bus.iob_rdata = 32'h55AA_55AA;
        end
      end else if (hold_ready) begin
        wait_cnt = 0;
      end else if (wait_cnt >= 2) begin
        bus.iob_ready = 1'b1;
        bus.iob_rdata = mem_model(bus.iob_addr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: compares every accepted IOb beat and every response beat
  initial begin
    iob_exp_t e;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (!rst && bus.iob_valid && bus.iob_ready) begin
        if (exp_iob.size() == 0) begin
          chk("iob_unexpected", {32'd0, bus.iob_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_iob.pop_front();
          chk("iob_addr", {32'd0, bus.iob_addr}, {32'd0, e.addr});
          chk("iob_wstrb", {60'd0, bus.iob_wstrb}, {60'd0, e.strb});
          if (e.strb != 4'h0) chk("iob_wdata", {32'd0, bus.iob_wdata}, {32'd0, e.wdata});
        end
      end
      if (bus.rsp_valid) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", {32'd0, bus.rsp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_data", {32'd0, bus.rsp_data}, {32'd0, r.data});
          chk("rsp_last", {63'd0, bus.rsp_last}, {63'd0, r.last});
          chk("rsp_error", {63'd0, bus.rsp_error}, {63'd0, r.err});
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int n;
    int base;
    rst  = 1'b1;
    boot = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_mask  = '0;
    bus.cmd_size  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iob", {bus.iob_valid, bus.iob_addr, bus.iob_wstrb}, 64'd0);
    chk("rst_iob_wdata", {32'd0, bus.iob_wdata}, 64'd0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_last, bus.rsp_error}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);

    // 1. Word read, latency t+1
    exp_read(32'h0000_0100, 1'b1, 1'b0);
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd2);
    chk("lat_iob_valid", {63'd0, bus.iob_valid}, 64'd1);
    wait_idle("word_read");

    // 2. Line read expands to 8 beats from the aligned base
    for (int i = 0; i < 8; i++) exp_read(32'h0000_1000 + 32'(i * 4), (i == 7), 1'b0);
    send_cmd(1'b0, 32'h0000_1004, 32'h0, 4'h0, 3'd5);
    wait_idle("line_read");

    // 3. Write with response
    exp_write(32'h0000_0200, 4'h3, 32'h1234_5678);
    send_cmd(1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 3'd2);
    wait_idle("write");

    // Stray iob_ready while idle must be ignored
    base = rsp_seen;
    @(negedge clk) stray_req = 1'b1;
    @(negedge clk) stray_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_ready", {32'd0, 31'd0, busy, 32'(rsp_seen - base)}, 64'd0);

    // 4. Back-pressure with a full FIFO
    exp_read(32'h0000_0500, 1'b1, 1'b0);
    exp_read(32'h0000_0504, 1'b1, 1'b0);
    exp_write(32'h0000_0600, 4'hF, 32'hCAFE_F00D);
    hold_ready = 1'b1;
    send_cmd(1'b0, 32'h0000_0500, 32'h0, 4'h0, 3'd2);
    send_cmd(1'b0, 32'h0000_0504, 32'h0, 4'h0, 3'd2);
    @(posedge clk); #1;
    drive_cmd(1'b1, 32'h0000_0600, 32'hCAFE_F00D, 4'hF, 3'd2);
    repeat (3) @(negedge clk);
    chk("full_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
    hold_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.iob_valid && bus.iob_ready) && n < 50);
    chk("bp_first_done", {63'd0, bus.iob_ready}, 64'd1);
    chk("bp_no_lookahead", {63'd0, bus.cmd_ready}, 64'd0);
    @(negedge clk);
    chk("bp_accept_next", {63'd0, bus.cmd_ready}, 64'd1);
    chk("bp_back_to_back", {31'd0, bus.iob_valid, bus.iob_addr}, {31'd0, 1'b1, 32'h0000_0504});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_idle("backpressure");

    // 5a. Oversize read is clamped and flagged on every beat
    for (int i = 0; i < 8; i++) exp_read(32'h0000_2000 + 32'(i * 4), (i == 7), 1'b1);
    send_cmd(1'b0, 32'h0000_2024, 32'h0, 4'h0, 3'd6);
    wait_idle("oversize");

    // 5b. Reset after beat 3 of 8
    base = rsp_seen;
    for (int i = 0; i < 8; i++) exp_read(32'h0000_3000 + 32'(i * 4), (i == 7), 1'b0);
    send_cmd(1'b0, 32'h0000_3010, 32'h0, 4'h0, 3'd5);
    n = 0;
    while (rsp_seen < base + 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("mid_rst_beats", 64'(rsp_seen - base), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_iob", {bus.iob_valid, bus.iob_addr, bus.iob_wstrb}, 64'd0);
    chk("mid_rst_rsp_busy", {30'd0, busy, bus.rsp_valid, bus.rsp_data}, 64'd0);
    exp_iob.delete();
    exp_rsp.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    base = rsp_seen;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_quiet", {31'd0, busy, 32'(rsp_seen - base)}, 64'd0);
    exp_read(32'h0000_0404, 1'b1, 1'b0);
    send_cmd(1'b0, 32'h0000_0404, 32'h0, 4'h0, 3'd2);
    wait_idle("post_rst_read");

    // 6. Boot-based remap of the address MSB
    @(posedge clk); #1 boot = 1'b0;
    exp_read(32'h8000_0040, 1'b1, 1'b0);
    send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd2);
    wait_idle("remap_boot0");
    @(posedge clk); #1 boot = 1'b1;
    exp_read(32'h0000_0040, 1'b1, 1'b0);
    send_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd2);
    wait_idle("remap_boot1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob_cmdrsp_bridge.md
Name: iob_cmdrsp_bridge

Overview:
Parametrised bridge from a split command/response CPU bus (VexRiscv-style iBus/dBus) to the IOb native bus. It buffers up to DEPTH outstanding commands and expands cache-line reads into multi-beat IOb transfers. It generates per-beat responses with a last flag and optionally remaps addresses to external memory based on boot. One instance sits on each CPU bus port between the core and the interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; power of 2, at least 32
DEPTH, 2, command FIFO entries; power of 2, at least 2
MAX_BEATS, 8, maximum read burst length in beats; power of 2
WR_RSP, 0, 1 = emit one response per write; 0 = writes are silent
RSP_REG, 0, 1 = register responses (+1 cycle); 0 = response in the iob_ready cycle
REMAP, 0, 1 = enable boot-based address remap of the MSB

Ports:
clk  in  1  clock
rst  in  1  reset
boot  in  1  boot-in-progress; used only when REMAP=1
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_mask  in  DATA_W/8  write byte enables
cmd_size  in  3  log2 of transfer bytes
rsp_valid  out  1  response beat valid; no backpressure
rsp_data  out  DATA_W  read data
rsp_last  out  1  final beat of the command
rsp_error  out  1  oversize command flag
iob_valid  out  1  IOb request valid
iob_addr  out  ADDR_W  IOb address
iob_wdata  out  DATA_W  IOb write data
iob_wstrb  out  DATA_W/8  IOb strobes; all 0 = read
iob_rdata  in  DATA_W  IOb read data, valid with iob_ready
iob_ready  in  1  IOb completion pulse
busy  out  1  FIFO non-empty or beat in flight

Behaviour:
- One clock, clk. rst is asynchronous, active-high.
- Reset:
  - iob_valid, iob_addr, iob_wdata, iob_wstrb, rsp_* and busy are 0.
  - FIFO is empty; beat counter is 0; FSM is in IDLE.
  - cmd_ready = !full, so it reads 1 once reset releases.
- Reset mid-burst: the transfer is abandoned and no further rsp is produced.
- Command accept:
  - cmd_ready = !full. There is no look-ahead on a same-cycle pop.
  - Push and pop in the same cycle when not full: both occur and the count is unchanged.
- Each FIFO entry stores wr, addr, wdata, strb and beats. strb = cmd_mask if wr, else 0.
- Beat count:
  - beats = 1 if cmd_size <= log2(DATA_W/8) or wr=1.
  - Otherwise beats = 2^cmd_size / (DATA_W/8).
  - If that exceeds MAX_BEATS: clamp to MAX_BEATS and set rsp_error=1 on every beat of that command.
- FSM states: IDLE, ISSUE.
  - IDLE -> ISSUE when the FIFO is non-empty.
  - In ISSUE, iob_valid=1 and the payload is taken from the FIFO head.
  - Beat address = (cmd_addr with low cmd_size bits cleared) + cnt*(DATA_W/8).
  - Single-beat commands use cmd_addr unchanged.
  - Payload is held stable until iob_ready.
  - iob_ready while iob_valid=0 is ignored.
- On iob_ready:
  - Not the final beat: cnt++.
  - Final beat: pop, cnt=0. Stay in ISSUE with the next head (back-to-back, no idle cycle) if one remains, else go to IDLE.
- Latency: command accepted at cycle t -> iob_valid at t+1. There is no bypass.
- Read responses:
  - One rsp_valid pulse per beat, rsp_data = iob_rdata.
  - Timing: in the iob_ready cycle when RSP_REG=0; the following cycle when RSP_REG=1.
  - rsp_last=1 only on the final beat.
- Write responses:
  - WR_RSP=1: one pulse with rsp_last=1 and rsp_data=0.
  - WR_RSP=0: none.
- Remap (REMAP=1): iob_addr[ADDR_W-1] = ~boot | beat_addr[ADDR_W-1]. REMAP=0: passthrough.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package: STRB_W=DATA_W/8, OFF_W=log2(STRB_W), BEAT_W=log2(MAX_BEATS)+1, FIFO entry width and field offsets, FSM state encoding.
- Sub-module iob_cmd_fifo: DEPTH-entry synchronous FIFO with async reset, full/empty flags and registered head.
- The top level holds the FSM, beat counter, address generation and response stage.

Test Plan:
1. Word read: read 0x100, size 2; iob_ready 2 cycles after iob_valid, rdata 0xDEADBEEF -> iob_valid at t+1 with addr 0x100 and wstrb 0; rsp_valid with 0xDEADBEEF and rsp_last=1 in the ready cycle (RSP_REG=0) or one cycle later (RSP_REG=1).
2. Line read: read 0x1004, size 5 -> 8 beats at 0x1000,0x1004..0x101C; rsp_last only on beat 8; rsp_error=0.
3. Write: 0x200, wdata 0x12345678, mask 0x3 -> iob_wstrb 0x3. WR_RSP=0: no rsp. WR_RSP=1: one rsp with last=1.
4. Back-pressure: DEPTH=2, iob_ready held low, 3 commands offered -> two accepted, cmd_ready=0 for the third. It is accepted the cycle after the first completes, and the next iob request follows with no idle cycle.
5. Edge cases:
   - Reset after beat 3 of 8: all outputs 0 at once, no further rsp. A new read afterwards starts at its own address.
   - Size 6 read with MAX_BEATS=8: 8 beats, rsp_error=1 on each.
6. REMAP=1, address 0x00000040: boot=0 -> iob_addr 0x80000040; boot=1 -> 0x00000040.
